dp_ram_arbiter: RTL

Two-client arbiter that shares the single write port and single read port of the dual-port RAM (`dp_ram_rtl`) between two independent requesters. Read and write ports are arbitrated separately with round-robin fairness. Read responses are routed back to the granted client with fixed latency. A same-cycle read/write to one address returns the new write data. The block sits directly in front of the RAM: client logic drives requests into it, and it drives the RAM's enable, address and data pins.

---
 rtl/dp_ram_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dp_ram_arbiter.sv
// dp_ram_arbiter: round-robin sharing of one RAM write port and one RAM read
// port between two clients. Read data returns one cycle after the read grant,
// routed to the granted client. A read and a write to the same address granted
// in the same cycle return the newly written data.
//
// Handshake: a client raises req with stable addr/data and holds them until
// gnt. A transfer happens in any cycle where req && gnt; gnt is combinational
// from req, the priority pointer and rst_in. Dropping req before gnt abandons
// the request with no side effect. Read responses carry no ready: cN_rd_valid
// is a one-cycle pulse exactly one cycle after the matching cN_rd_gnt.
module dp_ram_arbiter #(
    parameter int addr_width = 8,
    parameter int data_width = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  c0_wr_req,
    input  logic [addr_width-1:0] c0_wr_addr,
    input  logic [data_width-1:0] c0_wr_data,
    output logic                  c0_wr_gnt,
    input  logic                  c0_rd_req,
    input  logic [addr_width-1:0] c0_rd_addr,
    output logic                  c0_rd_gnt,
    output logic                  c0_rd_valid,
    output logic [data_width-1:0] c0_rd_data,
    input  logic                  c1_wr_req,
    input  logic [addr_width-1:0] c1_wr_addr,
    input  logic [data_width-1:0] c1_wr_data,
    output logic                  c1_wr_gnt,
    input  logic                  c1_rd_req,
    input  logic [addr_width-1:0] c1_rd_addr,
    output logic                  c1_rd_gnt,
    output logic                  c1_rd_valid,
    output logic [data_width-1:0] c1_rd_data,
    output logic                  ram_wr_en,
    output logic [addr_width-1:0] ram_wr_addr,
    output logic [data_width-1:0] ram_data_in,
    output logic                  ram_rd_en,
    output logic [addr_width-1:0] ram_rd_addr,
    input  logic [data_width-1:0] ram_data_out
);

    // Priority pointers: 0 favours client 0, 1 favours client 1.
    logic                  wr_pri_q, wr_pri_d;
    logic                  rd_pri_q, rd_pri_d;
    // Single in-flight read response.
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  fwd_q, fwd_d;
    logic [data_width-1:0] fwd_data_q, fwd_data_d;
    logic [data_width-1:0] rsp_data;

    // Grant decision per port: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        c0_wr_gnt = 1'b0;
        c1_wr_gnt = 1'b0;
        c0_rd_gnt = 1'b0;
        c1_rd_gnt = 1'b0;
        if (!rst_in) begin
            c0_wr_gnt = c0_wr_req && (!c1_wr_req || !wr_pri_q);
            c1_wr_gnt = c1_wr_req && (!c0_wr_req ||  wr_pri_q);
            c0_rd_gnt = c0_rd_req && (!c1_rd_req || !rd_pri_q);
            c1_rd_gnt = c1_rd_req && (!c0_rd_req ||  rd_pri_q);
        end
    end

    // RAM pin drive: mux the granted client's address/data, zero when idle.
    always_comb begin
        ram_wr_en   = c0_wr_gnt | c1_wr_gnt;
        ram_wr_addr = '0;
        ram_data_in = '0;
        ram_rd_en   = c0_rd_gnt | c1_rd_gnt;
        ram_rd_addr = '0;
        if (c0_wr_gnt) begin
            ram_wr_addr = c0_wr_addr;
            ram_data_in = c0_wr_data;
        end else if (c1_wr_gnt) begin
            ram_wr_addr = c1_wr_addr;
            ram_data_in = c1_wr_data;
        end
        if (c0_rd_gnt) begin
            ram_rd_addr = c0_rd_addr;
        end else if (c1_rd_gnt) begin
            ram_rd_addr = c1_rd_addr;
        end
    end

    // Next state: pointers move away from the granted client; response
    // tracking captures this cycle's read grant and any same-address write.
    always_comb begin
        wr_pri_d   = wr_pri_q;
        rd_pri_d   = rd_pri_q;
        if (c0_wr_gnt) begin
            wr_pri_d = 1'b1;
        end else if (c1_wr_gnt) begin
            wr_pri_d = 1'b0;
        end
        if (c0_rd_gnt) begin
            rd_pri_d = 1'b1;
        end else if (c1_rd_gnt) begin
            rd_pri_d = 1'b0;
        end
        rsp_vld_d  = ram_rd_en;
        rsp_id_d   = c1_rd_gnt;
        // The RAM returns old data on a same-cycle collision, so keep the
        // write data to present write-first behaviour.
        fwd_d      = ram_rd_en && ram_wr_en && (ram_rd_addr == ram_wr_addr);
        fwd_data_d = fwd_d ? ram_data_in : fwd_data_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_pri_q   <= 1'b0;
            rd_pri_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            wr_pri_q   <= wr_pri_d;
            rd_pri_q   <= rd_pri_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Response routing to the client that owned the read grant.
    always_comb begin
        rsp_data    = fwd_q ? fwd_data_q : ram_data_out;
        c0_rd_valid = rsp_vld_q && !rsp_id_q;
        c1_rd_valid = rsp_vld_q &&  rsp_id_q;
        c0_rd_data  = c0_rd_valid ? rsp_data : '0;
        c1_rd_data  = c1_rd_valid ? rsp_data : '0;
    end

endmodule
